// File: rtl/alu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_seq_if
//  Purpose  : Bundle between the instruction source and alu_ctrl_seq. It
//             carries the instruction push handshake and the datapath
//             control strobes that the sequencer drives.
//  Modports : master - instruction source / datapath side
//             slave  - the sequencer (alu_ctrl_seq)
//  Signals  : instr_valid, instr_ready, instr
//             alu_op, a_sel_b, b_sel_c, out_rd, in_wr, out_wr
//             busy, done, err
//             retire_cnt, err_cnt (only when CTRL_SEQ_PERF_EN is defined)
//  Config   : CTRL_SEQ_PERF_EN adds the performance counter signals.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_ctrl_seq_if #(
    parameter int NREG    = 3,
    parameter int NOUT    = 3,
    parameter int ALU_OPW = 4
);
    // Index width covers the larger register bank, never narrower than 1 bit.
    localparam int MAXN    = (NREG > NOUT) ? NREG : NOUT;
    localparam int IW      = (MAXN > 2) ? $clog2(MAXN) : 1;
    localparam int INSTR_W = ALU_OPW + 2 * IW + 2;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ALU_OPW-1:0] alu_op;
    logic               a_sel_b;
    logic               b_sel_c;
    logic [NOUT-1:0]    out_rd;
    logic [NREG-1:0]    in_wr;
    logic [NOUT-1:0]    out_wr;
    logic               busy;
    logic               done;
    logic               err;
`ifdef CTRL_SEQ_PERF_EN
    logic [31:0]        retire_cnt;
    logic [15:0]        err_cnt;

    modport master (
        output instr_valid, instr,
        input  instr_ready, alu_op, a_sel_b, b_sel_c, out_rd, in_wr, out_wr,
        input  busy, done, err, retire_cnt, err_cnt
    );
    modport slave (
        input  instr_valid, instr,
        output instr_ready, alu_op, a_sel_b, b_sel_c, out_rd, in_wr, out_wr,
        output busy, done, err, retire_cnt, err_cnt
    );
`else
    modport master (
        output instr_valid, instr,
        input  instr_ready, alu_op, a_sel_b, b_sel_c, out_rd, in_wr, out_wr,
        input  busy, done, err
    );
    modport slave (
        input  instr_valid, instr,
        output instr_ready, alu_op, a_sel_b, b_sel_c, out_rd, in_wr, out_wr,
        output busy, done, err
    );
`endif
endinterface : alu_ctrl_seq_if
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_seq
//  Purpose  : Multi-cycle ALU control sequencer. Instructions are queued in
//             a small FIFO, then decoded and executed by an FSM that drives
//             register-file read/write strobes and the ALU opcode.
//  Ports    : clk  - clock, all logic on posedge
//             rst  - synchronous reset, active-high
//             bus  - alu_ctrl_seq_if.slave (instruction push handshake,
//                    datapath strobes, busy/done/err status)
//  Instr    : {sel_b, use_fb, fb[IW], dst[IW], op[ALU_OPW]}
//  Config   : CTRL_SEQ_PERF_EN - when defined, adds retire_cnt (+1 per done)
//             and err_cnt (+1 per err), both cleared by rst and wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_seq #(
    parameter int                 NREG       = 3,
    parameter int                 NOUT       = 3,
    parameter int                 ALU_OPW    = 4,
    parameter int                 ALU_LAT    = 1,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [ALU_OPW-1:0] LOAD_OP    = ALU_OPW'(4'h9)
) (
    input  logic          clk,
    input  logic          rst,
    alu_ctrl_seq_if.slave bus
);
    localparam int MAXN     = (NREG > NOUT) ? NREG : NOUT;
    localparam int IW       = (MAXN > 2) ? $clog2(MAXN) : 1;
    localparam int INSTR_W  = ALU_OPW + 2 * IW + 2;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int LAT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    // Instruction field offsets.
    localparam int OFS_DST  = ALU_OPW;
    localparam int OFS_FB   = ALU_OPW + IW;
    localparam int OFS_UFB  = ALU_OPW + 2 * IW;
    localparam int OFS_SELB = OFS_UFB + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT - 1);
    localparam logic [NREG-1:0]  ONE_NREG = NREG'(1);
    localparam logic [NOUT-1:0]  ONE_NOUT = NOUT'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------------
    logic [INSTR_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               full_w;
    logic               empty_w;
    logic               push_w;
    logic               pop_w;

    // Readiness depends only on the registered count, so a pop in the same
    // cycle never lets a push into a full queue.
    assign full_w          = (cnt_q == FULL_CNT);
    assign empty_w         = (cnt_q == '0);
    assign push_w          = bus.instr_valid && !full_w;
    assign cnt_d           = cnt_q + CNT_W'(push_w) - CNT_W'(pop_w);
    assign bus.instr_ready = !full_w;

    always_ff @(posedge clk) begin
        if (push_w) begin
            fifo_mem_q[wr_ptr_q] <= bus.instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_w)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [LAT_W-1:0]   lat_q, lat_d;

    // Registered outputs and their next values.
    logic [ALU_OPW-1:0] alu_op_q,  alu_op_d;
    logic               a_sel_b_q, a_sel_b_d;
    logic               b_sel_c_q, b_sel_c_d;
    logic [NOUT-1:0]    out_rd_q,  out_rd_d;
    logic [NREG-1:0]    in_wr_q,   in_wr_d;
    logic [NOUT-1:0]    out_wr_q,  out_wr_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               err_q,     err_d;

    // Index checks on the instruction currently held in DECODE.
    logic is_load_w;
    logic bad_idx_w;

    assign is_load_w = (ir_q[ALU_OPW-1:0] == LOAD_OP);
    assign bad_idx_w = (is_load_w ? (int'(ir_q[OFS_DST +: IW]) >= NREG)
                                  : (int'(ir_q[OFS_DST +: IW]) >= NOUT))
                     || (ir_q[OFS_UFB] && (int'(ir_q[OFS_FB +: IW]) >= NOUT));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        lat_d   = lat_q;
        pop_w   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    pop_w   = 1'b1;
                    ir_d    = fifo_mem_q[rd_ptr_q];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bad_idx_w) begin
                    state_d = S_ERR;
                end else if (is_load_w) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_EXEC;
                    lat_d   = LAT_INIT;
                end
            end
            S_EXEC: begin
                if (lat_q == '0) state_d = S_WB;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            S_LOAD, S_WB, S_ERR: begin
                // Retiring state: chain straight into the next decode when
                // work is waiting, skipping the IDLE bubble.
                if (!empty_w) begin
                    pop_w   = 1'b1;
                    ir_d    = fifo_mem_q[rd_ptr_q];
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and next instruction so that
    // the registered strobes line up with the state they belong to.
    always_comb begin
        alu_op_d  = '0;
        a_sel_b_d = 1'b0;
        b_sel_c_d = 1'b0;
        out_rd_d  = '0;
        in_wr_d   = '0;
        out_wr_d  = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = (state_d != S_IDLE) || (cnt_d != '0);

        case (state_d)
            S_LOAD: begin
                in_wr_d  = ONE_NREG << ir_d[OFS_DST +: IW];
                out_rd_d = ir_d[OFS_UFB] ? (ONE_NOUT << ir_d[OFS_FB +: IW]) : '0;
                done_d   = 1'b1;
            end
            S_EXEC, S_WB: begin
                alu_op_d  = ir_d[ALU_OPW-1:0];
                a_sel_b_d = ir_d[OFS_SELB];
                b_sel_c_d = !ir_d[OFS_UFB];
                out_rd_d  = ir_d[OFS_UFB] ? (ONE_NOUT << ir_d[OFS_FB +: IW]) : '0;
                if (state_d == S_WB) begin
                    out_wr_d = ONE_NOUT << ir_d[OFS_DST +: IW];
                    done_d   = 1'b1;
                end
            end
            S_ERR: begin
                err_d  = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            lat_q     <= '0;
            alu_op_q  <= '0;
            a_sel_b_q <= 1'b0;
            b_sel_c_q <= 1'b0;
            out_rd_q  <= '0;
            in_wr_q   <= '0;
            out_wr_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            lat_q     <= lat_d;
            alu_op_q  <= alu_op_d;
            a_sel_b_q <= a_sel_b_d;
            b_sel_c_q <= b_sel_c_d;
            out_rd_q  <= out_rd_d;
            in_wr_q   <= in_wr_d;
            out_wr_q  <= out_wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.alu_op  = alu_op_q;
    assign bus.a_sel_b = a_sel_b_q;
    assign bus.b_sel_c = b_sel_c_q;
    assign bus.out_rd  = out_rd_q;
    assign bus.in_wr   = in_wr_q;
    assign bus.out_wr  = out_wr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

`ifdef CTRL_SEQ_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters, updated on the same edge as done/err.
    // ------------------------------------------------------------------------
    logic [31:0] retire_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            if (done_d) retire_cnt_q <= retire_cnt_q + 32'd1;
            if (err_d)  err_cnt_q    <= err_cnt_q + 16'd1;
        end
    end

    assign bus.retire_cnt = retire_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
`endif

endmodule : alu_ctrl_seq
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_seq
//  Purpose  : Self-checking bench for alu_ctrl_seq. Two instances (ALU
//             latency 1 and 4) share one stimulus stream; each is compared
//             every cycle against a timeline model that derives, per
//             accepted instruction, its decode cycle and retire cycle.
//  Config   : CTRL_SEQ_PERF_EN also checks retire_cnt / err_cnt.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_seq;
    localparam int         NREG       = 3;
    localparam int         NOUT       = 3;
    localparam int         ALU_OPW    = 4;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [3:0] LOAD_OP    = 4'h9;
    localparam int         NDUT       = 2;
    localparam int         LAT0       = 1;
    localparam int         LAT1       = 4;
    localparam int         MAXI       = 4096;

    typedef struct packed {
        logic       rdy;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] in_wr;
        logic [2:0] out_wr;
        logic [2:0] out_rd;
        logic [3:0] op;
        logic       asel;
        logic       bsel;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_valid;
    logic [9:0] tb_instr;
    obs_t       obs [NDUT];
`ifdef CTRL_SEQ_PERF_EN
    logic [31:0] obs_ret  [NDUT];
    logic [15:0] obs_errc [NDUT];
`endif

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        alu_ctrl_seq_if #(.NREG(NREG), .NOUT(NOUT), .ALU_OPW(ALU_OPW)) bus ();

        alu_ctrl_seq #(
            .NREG       (NREG),
            .NOUT       (NOUT),
            .ALU_OPW    (ALU_OPW),
            .ALU_LAT    ((gi == 0) ? LAT0 : LAT1),
            .FIFO_DEPTH (FIFO_DEPTH),
            .LOAD_OP    (LOAD_OP)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.instr_valid = tb_valid;
        assign bus.instr       = tb_instr;
        assign obs[gi] = {bus.instr_ready, bus.busy, bus.done, bus.err,
                          bus.in_wr, bus.out_wr, bus.out_rd, bus.alu_op,
                          bus.a_sel_b, bus.b_sel_c};
`ifdef CTRL_SEQ_PERF_EN
        assign obs_ret[gi]  = bus.retire_cnt;
        assign obs_errc[gi] = bus.err_cnt;
`endif
    end

    // ------------------------------------------------------------------------
    // Reference model: per DUT, a list of accepted instructions with the
    // cycle they sit in DECODE (D) and the cycle they retire (E). Cycle t is
    // the interval following clock edge t.
    // ------------------------------------------------------------------------
    logic [9:0] m_ins   [NDUT][MAXI];
    int         m_D     [NDUT][MAXI];
    int         m_E     [NDUT][MAXI];
    int         m_n     [NDUT];
    int         m_base  [NDUT];
    int         m_lastE [NDUT];
    int         m_ret   [NDUT];
    int         m_errc  [NDUT];
    int         t;
    int         n_checks;
    int         n_pass;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, t, got, want);
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic bit is_bad(input logic [9:0] ins);
        int dst = int'(ins[5:4]);
        int fb  = int'(ins[7:6]);
        bit ld  = (ins[3:0] == LOAD_OP);
        return (ld ? (dst >= NREG) : (dst >= NOUT)) || (ins[8] && (fb >= NOUT));
    endfunction

    function automatic int body_len(input int d, input logic [9:0] ins);
        if (is_bad(ins) || ins[3:0] == LOAD_OP) return 1;
        return lat_of(d) + 1;
    endfunction

    // Instructions accepted but not yet taken out of the queue at cycle tt.
    function automatic int occ_at(input int d, input int tt);
        int c = 0;
        for (int k = m_base[d]; k < m_n[d]; k++)
            if (m_D[d][k] > tt) c++;
        return c;
    endfunction

    task automatic model_reset(input int d);
        m_base[d]  = m_n[d];
        m_lastE[d] = -10;
        m_ret[d]   = 0;
        m_errc[d]  = 0;
    endtask

    task automatic check_dut(input int d);
        obs_t       e;
        int         act;
        int         occ;
        logic [9:0] ins;
        string      p;
        e   = '0;
        act = -1;
        p   = $sformatf("d%0d.", d);
        while (m_base[d] < m_n[d] && m_E[d][m_base[d]] < t) m_base[d]++;
        occ = occ_at(d, t);
        for (int k = m_base[d]; k < m_n[d]; k++)
            if (m_D[d][k] <= t && t <= m_E[d][k]) act = k;
        if (act >= 0 && t > m_D[d][act]) begin
            ins = m_ins[d][act];
            if (is_bad(ins)) begin
                e.err  = 1'b1;
                e.done = 1'b1;
            end else if (ins[3:0] == LOAD_OP) begin
                e.in_wr  = 3'b001 << ins[5:4];
                e.out_rd = ins[8] ? (3'b001 << ins[7:6]) : 3'b000;
                e.done   = 1'b1;
            end else begin
                e.op     = ins[3:0];
                e.asel   = ins[9];
                e.bsel   = !ins[8];
                e.out_rd = ins[8] ? (3'b001 << ins[7:6]) : 3'b000;
                if (t == m_E[d][act]) begin
                    e.out_wr = 3'b001 << ins[5:4];
                    e.done   = 1'b1;
                end
            end
        end
        e.busy = (act >= 0) || (occ > 0);
        e.rdy  = (occ < FIFO_DEPTH);
        if (e.done) m_ret[d]++;
        if (e.err)  m_errc[d]++;

        chk_val({p, "rdy"},    32'(obs[d].rdy),    32'(e.rdy));
        chk_val({p, "busy"},   32'(obs[d].busy),   32'(e.busy));
        chk_val({p, "done"},   32'(obs[d].done),   32'(e.done));
        chk_val({p, "err"},    32'(obs[d].err),    32'(e.err));
        chk_val({p, "in_wr"},  32'(obs[d].in_wr),  32'(e.in_wr));
        chk_val({p, "out_wr"}, 32'(obs[d].out_wr), 32'(e.out_wr));
        chk_val({p, "out_rd"}, 32'(obs[d].out_rd), 32'(e.out_rd));
        chk_val({p, "alu_op"}, 32'(obs[d].op),     32'(e.op));
        chk_val({p, "a_sel_b"},32'(obs[d].asel),   32'(e.asel));
        chk_val({p, "b_sel_c"},32'(obs[d].bsel),   32'(e.bsel));
`ifdef CTRL_SEQ_PERF_EN
        chk_val({p, "retire_cnt"}, obs_ret[d],        32'(m_ret[d]));
        chk_val({p, "err_cnt"},    32'(obs_errc[d]),  32'(m_errc[d] % 65536));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check outputs
    // on the following falling edge.
    task automatic cycle(input logic r, input logic v, input logic [9:0] ins);
        bit rdy [NDUT];
        int dd;
        rst      = r;
        tb_valid = v;
        tb_instr = ins;
        for (int d = 0; d < NDUT; d++) rdy[d] = (occ_at(d, t) < FIFO_DEPTH);
        @(posedge clk);
        t++;
        for (int d = 0; d < NDUT; d++) begin
            if (r) begin
                model_reset(d);
            end else if (v && rdy[d]) begin
                if (m_n[d] >= MAXI) begin
                    $display("FAIL model_capacity @cycle %0d: got %0d expected below %0d", t, m_n[d], MAXI);
                    $fatal(1);
                end
                dd = (t + 1 > m_lastE[d] + 1) ? t + 1 : m_lastE[d] + 1;
                m_ins[d][m_n[d]] = ins;
                m_D[d][m_n[d]]   = dd;
                m_E[d][m_n[d]]   = dd + body_len(d, ins);
                m_lastE[d]       = m_E[d][m_n[d]];
                m_n[d]++;
            end
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_dut(d);
    endtask

    initial begin
        logic [9:0] ins;
        logic       r;
        logic       v;
        rst      = 1'b1;
        tb_valid = 1'b0;
        tb_instr = '0;
        t        = 0;
        n_checks = 0;
        n_pass   = 0;
        for (int d = 0; d < NDUT; d++) begin
            m_n[d] = 0;
            model_reset(d);
        end

        // Reset state.
        cycle(1'b1, 1'b0, 10'h000);
        cycle(1'b1, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000);

        // Load dst1, then ALU op2 with feedback, then bad-index load followed
        // by a good instruction.
        cycle(1'b0, 1'b1, 10'h019);
        repeat (5) cycle(1'b0, 1'b0, 10'h000);
        cycle(1'b0, 1'b1, 10'h382);
        repeat (8) cycle(1'b0, 1'b0, 10'h000);
        cycle(1'b0, 1'b1, 10'h039);
        cycle(1'b0, 1'b1, 10'h382);
        repeat (10) cycle(1'b0, 1'b0, 10'h000);

        // Back-to-back ALU burst: fills the queue on the slower instance.
        for (int i = 0; i < 12; i++) begin
            ins = {1'b1, 1'b0, 2'b00, 2'(i % 3), 4'(i % 8)};
            cycle(1'b0, 1'b1, ins);
        end
        repeat (40) cycle(1'b0, 1'b0, 10'h000);

        // Reset while executing with instructions still queued.
        cycle(1'b0, 1'b1, 10'h112);
        cycle(1'b0, 1'b1, 10'h023);
        cycle(1'b0, 1'b1, 10'h205);
        repeat (3) cycle(1'b0, 1'b0, 10'h000);
        cycle(1'b1, 1'b0, 10'h000);
        repeat (6) cycle(1'b0, 1'b0, 10'h000);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 2) != 0);
            ins = 10'($urandom);
            if ($urandom_range(0, 3) == 0) ins[3:0] = LOAD_OP;
            cycle(r, v, ins);
        end
        repeat (60) cycle(1'b0, 1'b0, 10'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", t);
        $fatal(1);
    end

endmodule : tb_alu_ctrl_seq
`default_nettype wire
